// File: rtl/bank_port_arbiter_pkg.sv
// Shared widths, sizing helpers and kernel indexing for the bank port arbiter.
// Kernel k serves bank k/NPORTS, port k%NPORTS.
package bank_port_arbiter_pkg;

   localparam int DEF_NCONSUMERS = 8;
   localparam int DEF_NBANKS     = 4;
   localparam int DEF_NPORTS     = 2;
   localparam int DEF_MAX_WAIT   = 8;

   // Ceiling log2, never below 1 so single-entry fields keep a real bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

   localparam int CW = clog2(DEF_NCONSUMERS);
   localparam int BW = clog2(DEF_NBANKS);
   localparam int PW = clog2(DEF_NPORTS);

   function automatic int kernel_bank(input int k, input int nports);
      return k / nports;
   endfunction

   function automatic int kernel_port(input int k, input int nports);
      return k % nports;
   endfunction

   // Staggers the ports of one bank half a consumer ring apart.
   function automatic int pivot_init(input int k, input int nconsumers, input int nports);
      return (kernel_bank(k, nports) + kernel_port(k, nports) * (nconsumers / nports)) % nconsumers;
   endfunction

endpackage

// File: rtl/bank_port_arbiter_if.sv
// Request/grant bundle between consumers (master) and the bank port arbiter (slave).
interface bank_port_arbiter_if #(
   parameter int NCONSUMERS = 8,
   parameter int NBANKS     = 4,
   parameter int NPORTS     = 2
);
   import bank_port_arbiter_pkg::*;

   localparam int NK     = NBANKS * NPORTS;
   localparam int CONS_W = clog2(NCONSUMERS);
   localparam int BANK_W = clog2(NBANKS);
   localparam int PORT_W = clog2(NPORTS);

   logic [NCONSUMERS-1:0]             req_valid;
   logic [NCONSUMERS-1:0][BANK_W-1:0] req_bank;
   logic [NCONSUMERS-1:0]             gnt;
   logic [NCONSUMERS-1:0][PORT_W-1:0] gnt_port;
   logic [NK-1:0]                     kernel_valid;
   logic [NK-1:0][CONS_W-1:0]         kernel_consumer;

   modport master (
      output req_valid, req_bank,
      input  gnt, gnt_port, kernel_valid, kernel_consumer
   );

   modport slave (
      input  req_valid, req_bank,
      output gnt, gnt_port, kernel_valid, kernel_consumer
   );

endinterface

// File: rtl/bank_port_arbiter_rr_pick.sv
// Rotate-priority picker: first set bit of cand scanning upward from pivot, with wrap.
module rr_pick #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] cand,
   input  logic [W-1:0] pivot,
   output logic         found,
   output logic [W-1:0] idx
);

   logic [W-1:0] c;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      c     = '0;
      for (int i = 0; i < N; i++) begin
         c = pivot + W'(i);
         if (!found && cand[c]) begin
            found = 1'b1;
            idx   = c;
         end
      end
   end

endmodule

// File: rtl/bank_port_arbiter.sv
// Per-(bank,port) rotate-priority arbiter with staggered free-running pivots.
// Optional aged-first scheduling under BANK_PORT_ARBITER_STARVATION_GUARD_EN.
module bank_port_arbiter
   import bank_port_arbiter_pkg::*;
#(
   parameter int NCONSUMERS = DEF_NCONSUMERS,
   parameter int NBANKS     = DEF_NBANKS,
   parameter int NPORTS     = DEF_NPORTS
`ifdef BANK_PORT_ARBITER_STARVATION_GUARD_EN
   ,
   parameter int MAX_WAIT   = DEF_MAX_WAIT
`endif
) (
   input  logic               clk,
   input  logic               reset,
   bank_port_arbiter_if.slave bus
);

   localparam int NK     = NBANKS * NPORTS;
   localparam int CONS_W = clog2(NCONSUMERS);
   localparam int BANK_W = clog2(NBANKS);
   localparam int PORT_W = clog2(NPORTS);

   logic [CONS_W-1:0]                 rr_pivots [NK];
   logic [NCONSUMERS-1:0]             gnt_q, gnt_nxt;
   logic [NCONSUMERS-1:0][PORT_W-1:0] gnt_port_q, gnt_port_nxt;
   logic [NK-1:0]                     kv_q;
   logic [NK-1:0][CONS_W-1:0]         kc_q;
   logic [NK-1:0]                     pick_found;
   logic [NK-1:0][CONS_W-1:0]         pick_idx;
   logic [NCONSUMERS-1:0]             eligible;

   // A consumer granted last cycle sits out one cycle so it can drop or retarget.
   assign eligible = bus.req_valid & ~gnt_q;

`ifdef BANK_PORT_ARBITER_STARVATION_GUARD_EN
   localparam int WAIT_W = clog2(MAX_WAIT + 1);

   logic [WAIT_W-1:0]     wait_cnt [NCONSUMERS];
   logic [NCONSUMERS-1:0] aged;

   always_comb begin
      aged = '0;
      for (int c = 0; c < NCONSUMERS; c++) begin
         aged[c] = (wait_cnt[c] == WAIT_W'(MAX_WAIT));
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < NCONSUMERS; c++) wait_cnt[c] <= '0;
      end else begin
         for (int c = 0; c < NCONSUMERS; c++) begin
            if (gnt_nxt[c] || !bus.req_valid[c])
               wait_cnt[c] <= '0;
            else if (eligible[c] && !aged[c])
               wait_cnt[c] <= wait_cnt[c] + WAIT_W'(1);
         end
      end
   end
`endif

   for (genvar k = 0; k < NK; k++) begin : g_kernel
      localparam int KB = kernel_bank(k, NPORTS);

      logic [NCONSUMERS-1:0] taken_in, taken_out, bank_hit, open, cand;
      logic                  found;
      logic [CONS_W-1:0]     idx;

      // Lower-index kernels claim consumers first; the taken mask ripples upward.
      if (k == 0) begin : g_first
         assign taken_in = '0;
      end else begin : g_chain
         assign taken_in = g_kernel[k-1].taken_out;
      end

      always_comb begin
         bank_hit = '0;
         for (int c = 0; c < NCONSUMERS; c++) begin
            bank_hit[c] = (bus.req_bank[c] == BANK_W'(KB));
         end
      end

      assign open = eligible & bank_hit & ~taken_in;

`ifdef BANK_PORT_ARBITER_STARVATION_GUARD_EN
      assign cand = |(open & aged) ? (open & aged) : open;
`else
      assign cand = open;
`endif

      rr_pick #(.N(NCONSUMERS), .W(CONS_W)) u_pick (
         .cand  (cand),
         .pivot (rr_pivots[k]),
         .found (found),
         .idx   (idx)
      );

      assign taken_out     = taken_in | (found ? (NCONSUMERS'(1) << idx) : '0);
      assign pick_found[k] = found;
      assign pick_idx[k]   = idx;
   end

   always_comb begin
      gnt_nxt      = '0;
      gnt_port_nxt = gnt_port_q;
      for (int k = 0; k < NK; k++) begin
         if (pick_found[k]) begin
            gnt_nxt[pick_idx[k]]      = 1'b1;
            gnt_port_nxt[pick_idx[k]] = PORT_W'(kernel_port(k, NPORTS));
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_q      <= '0;
         gnt_port_q <= '0;
         kv_q       <= '0;
         kc_q       <= '0;
         for (int k = 0; k < NK; k++) begin
            rr_pivots[k] <= CONS_W'(pivot_init(k, NCONSUMERS, NPORTS));
         end
      end else begin
         gnt_q      <= gnt_nxt;
         gnt_port_q <= gnt_port_nxt;
         kv_q       <= pick_found;
         kc_q       <= pick_idx;
         for (int k = 0; k < NK; k++) begin
            rr_pivots[k] <= rr_pivots[k] + CONS_W'(1);
         end
      end
   end

   assign bus.gnt             = gnt_q;
   assign bus.gnt_port        = gnt_port_q;
   assign bus.kernel_valid    = kv_q;
   assign bus.kernel_consumer = kc_q;

endmodule

// File: doc/bank_port_arbiter.md
Name: bank_port_arbiter

Overview:
- Shares NBANKS memory banks, each with NPORTS ports, among NCONSUMERS requesters.
- One scheduling kernel per (bank, port) pair, NKERNELS = NBANKS*NPORTS, indexed k = b*NPORTS + p.
- Each kernel grants one consumer per cycle using rotate-priority from its own pivot. Pivots advance every cycle to give staggered round-robin fairness.
- Sits between consumer request logic and bank port muxes; drives per-port select and per-consumer grant.

Parameters:
- NCONSUMERS, 8, number of requesters (power of 2, divisible by NPORTS).
- NBANKS, 4, number of banks (power of 2).
- NPORTS, 2, ports per bank.
- MAX_WAIT, 8, starvation threshold in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NCONSUMERS  per-consumer request.
- req_bank  in  NCONSUMERS x clog2(NBANKS)  target bank per consumer.
- gnt  out  NCONSUMERS  registered one-cycle grant pulse.
- gnt_port  out  NCONSUMERS x clog2(NPORTS)  port granted, valid when gnt=1.
- kernel_valid  out  NKERNELS  port k drives an access this cycle.
- kernel_consumer  out  NKERNELS x clog2(NCONSUMERS)  consumer owning port k.

Behaviour:
- Pivot registers rr_pivots[k], width clog2(NCONSUMERS).
  - Reset value: (b + p*(NCONSUMERS/NPORTS)) mod NCONSUMERS. For defaults: 0,4,1,5,2,6,3,7.
  - Every clock edge with reset high: rr_pivots[k] <= (rr_pivots[k]+1) mod NCONSUMERS. Wraps 7->0, unconditionally.
- Eligibility: c is eligible this cycle iff req_valid[c]=1 and gnt[c]=0. A consumer just granted is ignored for one cycle, so it may drop or change its request. Max rate per consumer is one grant per 2 cycles.
- Resolution, combinational, kernels in ascending k:
  - Kernel k scans c = pivot, pivot+1, ... mod NCONSUMERS.
  - It picks the first c that is eligible, has req_bank[c]=b(k), and is not already taken by a lower-index kernel this cycle.
  - No candidate -> kernel idle.
  - A consumer gets at most one port per cycle.
- Registered outputs, one cycle latency: arbitration uses pre-edge pivots and inputs. At the edge:
  - gnt[c]=1 and gnt_port[c]=p(k) for each picked c.
  - kernel_valid[k] and kernel_consumer[k] are set.
  - Unpicked consumers: gnt=0; gnt_port holds its previous value.
- Handshake: consumer holds req_valid/req_bank stable until it sees gnt. Unbounded wait is permitted.
- Reset (async, any time):
  - gnt, gnt_port, kernel_valid, kernel_consumer -> 0 immediately.
  - Pivots -> reset values.
  - Outstanding requests are not remembered. The first grant appears at the first rising edge after reset deasserts.
- Simultaneous events: more requesters on a bank than NPORTS -> extras wait. Requests to other banks are independent.

Optional Feature:
- Macro: BANK_PORT_ARBITER_STARVATION_GUARD_EN.
- Defined:
  - Per-consumer saturating wait counter, width clog2(MAX_WAIT+1).
  - Increments on each edge where the consumer is eligible but not granted. Clears on grant or when req_valid=0. Resets to 0.
  - A consumer with counter == MAX_WAIT is "aged". Each kernel first scans aged consumers of its bank (rotate from pivot), then normal ones. Other rules unchanged.
- Undefined: no counters; pure pivot rotate-priority.

Decomposition:
- Package bank_port_arbiter_pkg:
  - clog2 helper.
  - Functions kernel_bank(k), kernel_port(k), pivot_init(k).
  - Width localparams CW, BW, PW.
- Sub-module rr_pick: one kernel's rotate-priority picker. Inputs: candidate mask, pivot. Outputs: found, index. Instantiated NKERNELS times in a generate loop with a chained taken-mask.

Test Plan (defaults):
1. Reset release, no requests -> rr_pivots = 0,4,1,5,2,6,3,7. Next edge 1,5,2,6,3,7,4,0. Next 2,6,3,7,4,0,5,1. After 8 edges, back to reset values.
2. Just after reset, all 8 consumers request bank 0 -> first edge: gnt for c0 (port 0) and c4 (port 1); kernel_consumer[0]=0, [1]=4; other kernels idle. Next edge: c1 and c5.
3. Consumers 0..3 request banks 0..3 in the first cycle -> all four granted on port 0; kernel_valid = kernels 0,2,4,6.
4. Consumer 7 holds a request to bank 2 continuously -> gnt[7] toggles 1,0,1,0; gnt_port[7]=0.
5. Assert reset while grants are active -> gnt and kernel_valid clear before the next edge; pivots return to reset values.
6. (Guard on, MAX_WAIT=2) c3 and c4 on bank 1 with NPORTS=1 and a contended pivot order -> the waiting consumer is granted within MAX_WAIT+2 cycles.
